digit_scan_ctrl: RTL
====================

// Module: digit_scan_ctrl
//
// PURPOSE
//   Parametrised multiplexed-display scan controller. Cycles one-hot digit
//   selects across NUM_DIGITS common-anode/cathode digits at a programmable
//   slot rate, inserts a blanking gap between digits (anti-ghosting), and
//   skips digits masked off at runtime. Drives the digit-select pins and the
//   digit index used by the segment decoder mux.
//
// PARAMETERS
//   NUM_DIGITS     4      number of digits scanned (>=1)
//   PRESCALE       50000  clock cycles per digit slot, blank + show (>=2)
//   BLANK_CYCLES   16     cycles all selects inactive at slot start (0..PRESCALE-1)
//   SEL_ACTIVE_LOW 1      1: active select = 0, idle = 1; 0: inverse
//   (localparam IDX_W = max(1,$clog2(NUM_DIGITS)); CNT_W = $clog2(PRESCALE))
//
// PORTS
//   i_clk         in   1           system clock
//   i_rst_n       in   1           synchronous reset, active low
//   i_en          in   1           scan enable
//   i_digit_mask  in   NUM_DIGITS  1 = digit scanned, 0 = skipped/never selected
//   o_idx         out  IDX_W       index of digit currently selected/pending
//   o_digit_sel   out  NUM_DIGITS  one-hot digit select, polarity per SEL_ACTIVE_LOW
//   o_blank       out  1           1 while no digit selected
//   o_frame_tick  out  1           1-cycle pulse when index wraps (new idx <= old idx)
//
// BEHAVIOUR
//   - All outputs registered. Reset (i_rst_n=0 at edge): state IDLE, slot
//     counter 0, o_idx 0, o_digit_sel all inactive, o_blank 1, o_frame_tick 0.
//     Reset wins over every other input, including mid-slot.
//   - States: IDLE, BLANK, SHOW.
//     IDLE : selects inactive, o_blank 1. If i_en=1 and mask!=0 -> BLANK,
//            counter=0, o_idx = first enabled digit at/above current o_idx
//            (wrapping). No frame tick on this load.
//     BLANK: selects inactive, o_blank 1 for BLANK_CYCLES cycles, then SHOW.
//            BLANK_CYCLES=0 -> IDLE/advance goes straight to SHOW.
//     SHOW : select bit o_idx active, o_blank 0, for PRESCALE-BLANK_CYCLES
//            cycles; then advance and enter BLANK (or SHOW if BLANK_CYCLES=0).
//   - Advance: next idx = first i=o_idx+1.. wrapping mod NUM_DIGITS with
//     i_digit_mask[i]=1; if only current digit enabled, idx unchanged.
//     o_frame_tick=1 for the one cycle after an advance whose new idx <= old.
//   - Mask sampled at advance. If i_digit_mask[o_idx] drops during SHOW,
//     select deasserts (o_blank 1) on the next edge; slot timing continues.
//   - Mask all zero in any state: -> IDLE next edge, selects inactive.
//   - i_en=0 in BLANK/SHOW: -> IDLE next edge, counter cleared, o_idx held.
//     Re-enable restarts with a full BLANK at the held index.
//   - Slot counter CNT_W bits, counts 0..PRESCALE-1, never overflows; exactly
//     one digit (or none) active in any cycle; no select overlap at transitions.
//
// TESTING  (NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2, SEL_ACTIVE_LOW=1)
//   1. Hold i_rst_n=0 3 cycles -> o_digit_sel=4'b1111, o_blank=1, o_idx=0,
//      o_frame_tick=0.
//   2. i_en=1, mask=4'b1111 -> repeating 2 cycles 1111 then 6 cycles each of
//      1110,1101,1011,0111; o_frame_tick once per 32 cycles on idx 3->0.
//   3. mask=4'b0101 -> o_idx 0,2,0,2; sel 1110/1011 only; tick on each 2->0.
//   4. mask=4'b0000 -> o_digit_sel=1111, o_blank=1 continuously, no tick;
//      mask=4'b1000 then -> idx 3 shown every slot, tick every slot.
//   5. i_en=0 at SHOW cycle 3 of idx 1 -> next edge sel=1111, o_idx=1;
//      i_en=1 -> 2 blank cycles then 1101 for 6 cycles.
//   6. i_rst_n=0 for 1 cycle during SHOW of idx 2 -> next edge full reset
//      values; scan restarts at idx 0 with 2 blank cycles.

Source files
------------

// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: multiplexed-display digit scanner with blanking gap and runtime digit masking.
module digit_scan_ctrl #(
  parameter int NUM_DIGITS     = 4,
  parameter int PRESCALE       = 50000,
  parameter int BLANK_CYCLES   = 16,
  parameter bit SEL_ACTIVE_LOW = 1'b1,
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int CNT_W = $clog2(PRESCALE)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic [NUM_DIGITS-1:0] i_digit_mask,
  output logic [IDX_W-1:0]      o_idx,
  output logic [NUM_DIGITS-1:0] o_digit_sel,
  output logic                  o_blank,
  output logic                  o_frame_tick
);
  localparam logic [NUM_DIGITS-1:0] OFF = SEL_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_load_idx;
  logic [IDX_W-1:0] w_adv_idx;
  logic             w_cur_on;
  function automatic logic [IDX_W-1:0] f_first(input logic [NUM_DIGITS-1:0] m, input int s);
    logic [IDX_W-1:0] r;
    logic             f;
    r = '0;
    f = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      int i;
      i = (s + k) % NUM_DIGITS;
      if (!f && m[i]) begin
        r = IDX_W'(i);
        f = 1'b1;
      end
    end
    return r;
  endfunction
  function automatic logic [NUM_DIGITS-1:0] f_sel(input logic [IDX_W-1:0] i, input logic on);
    logic [NUM_DIGITS-1:0] oh;
    oh    = '0;
    oh[i] = 1'b1;
    return on ? (SEL_ACTIVE_LOW ? ~oh : oh) : OFF;
  endfunction
  assign w_load_idx = f_first(i_digit_mask, int'(r_idx));
  assign w_adv_idx  = f_first(i_digit_mask, (int'(r_idx) + 1) % NUM_DIGITS);
  assign w_cur_on   = i_digit_mask[r_idx];
  assign o_idx      = r_idx;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_idx        <= '0;
      o_digit_sel  <= OFF;
      o_blank      <= 1'b1;
      o_frame_tick <= 1'b0;
    end else begin
      o_frame_tick <= 1'b0;
      if (i_digit_mask == '0 || (r_state != IDLE && !i_en)) begin
        r_state     <= IDLE;
        r_cnt       <= '0;
        o_digit_sel <= OFF;
        o_blank     <= 1'b1;
      end else begin
        case (r_state)
          IDLE: if (i_en) begin
            r_idx       <= w_load_idx;
            r_cnt       <= '0;
            r_state     <= (BLANK_CYCLES == 0) ? SHOW : BLANK;
            o_digit_sel <= f_sel(w_load_idx, BLANK_CYCLES == 0);
            o_blank     <= (BLANK_CYCLES != 0);
          end
          BLANK: begin
            r_cnt <= r_cnt + 1'b1;
            if (int'(r_cnt) == BLANK_CYCLES - 1) begin
              r_state     <= SHOW;
              o_digit_sel <= f_sel(r_idx, w_cur_on);
              o_blank     <= !w_cur_on;
            end
          end
          SHOW: begin
            if (int'(r_cnt) == PRESCALE - 1) begin
              // slot boundary: pick next enabled digit; wrap flags a new frame
              r_cnt        <= '0;
              r_idx        <= w_adv_idx;
              o_frame_tick <= (w_adv_idx <= r_idx);
              r_state      <= (BLANK_CYCLES == 0) ? SHOW : BLANK;
              o_digit_sel  <= f_sel(w_adv_idx, BLANK_CYCLES == 0);
              o_blank      <= (BLANK_CYCLES != 0);
            end else begin
              r_cnt       <= r_cnt + 1'b1;
              o_digit_sel <= f_sel(r_idx, w_cur_on);
              o_blank     <= !w_cur_on;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule
